// File: rtl/raycast_pkg.sv
// Shared raycaster types and constants: Q8.8 widths, map geometry, wall encoding
// and the DDA stepper state encoding.
package raycast_pkg;

    localparam int Q_W       = 16;
    localparam int FRAC_BITS = 8;
    localparam int COORD_W   = Q_W - FRAC_BITS;

    localparam int MAP_SIZE = 24;
    localparam int MAP_AW   = $clog2(MAP_SIZE * MAP_SIZE);
    localparam logic [COORD_W-1:0] MAP_MAX = COORD_W'(MAP_SIZE - 1);

    localparam int WALL_W = 4;
    localparam logic [WALL_W-1:0] OOB_TYPE = 4'hF;

    localparam int SCREEN_W = 320;
    localparam int HCOUNT_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        FETCH,
        WAIT,
        CHECK,
        DONE
    } dda_state_e;

endpackage

// File: rtl/dda_axis_step.sv
// One DDA axis: holds the running side distance, its per-cell delta and the
// pre-step value, advancing with a saturating Q8.8 add.
module dda_axis_step
    import raycast_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           load_in,
    input  logic           advance_in,
    input  logic [Q_W-1:0] side_init_in,
    input  logic [Q_W-1:0] delta_init_in,
    output logic [Q_W-1:0] side_dist_out,
    output logic [Q_W-1:0] prev_out
);

    logic [Q_W-1:0] side_q, side_d;
    logic [Q_W-1:0] delta_q, delta_d;
    logic [Q_W-1:0] prev_q, prev_d;
    logic [Q_W:0]   sum;

    assign sum = {1'b0, side_q} + {1'b0, delta_q};

    always_comb begin
        side_d  = side_q;
        delta_d = delta_q;
        prev_d  = prev_q;
        if (load_in) begin
            side_d  = side_init_in;
            delta_d = delta_init_in;
            prev_d  = '0;
        end else if (advance_in) begin
            // prev keeps the exact pre-step distance even once the running value pins at max
            prev_d = side_q;
            side_d = sum[Q_W] ? {Q_W{1'b1}} : sum[Q_W-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            side_q  <= '0;
            delta_q <= '0;
            prev_q  <= '0;
        end else begin
            side_q  <= side_d;
            delta_q <= delta_d;
            prev_q  <= prev_d;
        end
    end

    assign side_dist_out = side_q;
    assign prev_out      = prev_q;

endmodule

// File: rtl/dda_ray_stepper.sv
// DDA grid walker: takes one ray, walks the map BRAM until wall/edge/step limit,
// then offers the column hit. Optional DDA_STEP_COUNT_EN exports the step count.
module dda_ray_stepper
    import raycast_pkg::*;
#(
    parameter int MAP_LATENCY = 2,
    parameter int MAX_STEPS   = 64
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                valid_ray_in,
    output logic                dda_data_ready_out,
    input  logic [Q_W-1:0]      posX,
    input  logic [Q_W-1:0]      posY,
    input  logic                stepX,
    input  logic                stepY,
    input  logic [Q_W-1:0]      sideDistX,
    input  logic [Q_W-1:0]      sideDistY,
    input  logic [Q_W-1:0]      deltaDistX,
    input  logic [Q_W-1:0]      deltaDistY,
    input  logic [HCOUNT_W-1:0] hcount_in,
    output logic [MAP_AW-1:0]   map_addr_out,
    output logic                map_rd_out,
    input  logic [WALL_W-1:0]   map_data_in,
    output logic                valid_hit_out,
    input  logic                hit_ready_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [Q_W-1:0]      dist_out,
    output logic                side_out,
    output logic [WALL_W-1:0]   wall_type_out,
    output logic                timeout_out
`ifdef DDA_STEP_COUNT_EN
    ,
    output logic [$clog2(MAX_STEPS+1)-1:0] step_count_out
`endif
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam int WAIT_W = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

    dda_state_e state_q, state_d;

    logic                ready_q, ready_d;
    logic [COORD_W-1:0]  map_x_q, map_x_d;
    logic [COORD_W-1:0]  map_y_q, map_y_d;
    logic                step_x_q, step_x_d;
    logic                step_y_q, step_y_d;
    logic [HCOUNT_W-1:0] hcount_q, hcount_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                side_q, side_d;
    logic [WALL_W-1:0]   wall_q, wall_d;
    logic                timeout_q, timeout_d;
    logic [MAP_AW-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;

    logic           load;
    logic           adv_x;
    logic           adv_y;
    logic [Q_W-1:0] side_dist_x;
    logic [Q_W-1:0] side_dist_y;
    logic [Q_W-1:0] prev_x;
    logic [Q_W-1:0] prev_y;
    logic           oob_x;
    logic           oob_y;

    logic unused_pos_frac;
    assign unused_pos_frac = ^{posX[FRAC_BITS-1:0], posY[FRAC_BITS-1:0]};

    dda_axis_step u_axis_x (
        .clk_in        (pixel_clk_in),
        .rst_in        (rst_in),
        .load_in       (load),
        .advance_in    (adv_x),
        .side_init_in  (sideDistX),
        .delta_init_in (deltaDistX),
        .side_dist_out (side_dist_x),
        .prev_out      (prev_x)
    );

    dda_axis_step u_axis_y (
        .clk_in        (pixel_clk_in),
        .rst_in        (rst_in),
        .load_in       (load),
        .advance_in    (adv_y),
        .side_init_in  (sideDistY),
        .delta_init_in (deltaDistY),
        .side_dist_out (side_dist_y),
        .prev_out      (prev_y)
    );

    assign oob_x = step_x_q ? (map_x_q == MAP_MAX) : (map_x_q == '0);
    assign oob_y = step_y_q ? (map_y_q == MAP_MAX) : (map_y_q == '0);

    always_comb begin
        state_d   = state_q;
        map_x_d   = map_x_q;
        map_y_d   = map_y_q;
        step_x_d  = step_x_q;
        step_y_d  = step_y_q;
        hcount_d  = hcount_q;
        steps_d   = steps_q;
        wait_d    = wait_q;
        side_d    = side_q;
        wall_d    = wall_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        load      = 1'b0;
        adv_x     = 1'b0;
        adv_y     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_ray_in && ready_q) begin
                    load      = 1'b1;
                    map_x_d   = posX[Q_W-1:FRAC_BITS];
                    map_y_d   = posY[Q_W-1:FRAC_BITS];
                    step_x_d  = stepX;
                    step_y_d  = stepY;
                    hcount_d  = hcount_in;
                    steps_d   = '0;
                    side_d    = 1'b0;
                    wall_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = STEP;
                end
            end
            STEP: begin
                steps_d = steps_q + STEP_W'(1);
                // ties deliberately fall through to the Y axis
                if (side_dist_x < side_dist_y) begin
                    adv_x  = 1'b1;
                    side_d = 1'b0;
                    if (oob_x) begin
                        wall_d  = OOB_TYPE;
                        state_d = DONE;
                    end else begin
                        map_x_d = step_x_q ? map_x_q + COORD_W'(1) : map_x_q - COORD_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    adv_y  = 1'b1;
                    side_d = 1'b1;
                    if (oob_y) begin
                        wall_d  = OOB_TYPE;
                        state_d = DONE;
                    end else begin
                        map_y_d = step_y_q ? map_y_q + COORD_W'(1) : map_y_q - COORD_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                wait_d  = '0;
                state_d = (MAP_LATENCY > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                if (wait_q == WAIT_W'(MAP_LATENCY - 2)) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            CHECK: begin
                if (map_data_in != '0) begin
                    wall_d  = map_data_in;
                    state_d = DONE;
                end else if (steps_q == STEP_W'(MAX_STEPS)) begin
                    timeout_d = 1'b1;
                    wall_d    = '0;
                    state_d   = DONE;
                end else begin
                    state_d = STEP;
                end
            end
            DONE: begin
                if (hit_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // read strobe and address are registered so they line up with FETCH
        if (state_d == FETCH) begin
            rd_d   = 1'b1;
            addr_d = MAP_AW'(32'(map_y_d) * MAP_SIZE + 32'(map_x_d));
        end
    end

    assign ready_d = (state_d == IDLE);

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            map_x_q   <= '0;
            map_y_q   <= '0;
            step_x_q  <= 1'b0;
            step_y_q  <= 1'b0;
            hcount_q  <= '0;
            steps_q   <= '0;
            wait_q    <= '0;
            side_q    <= 1'b0;
            wall_q    <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            map_x_q   <= map_x_d;
            map_y_q   <= map_y_d;
            step_x_q  <= step_x_d;
            step_y_q  <= step_y_d;
            hcount_q  <= hcount_d;
            steps_q   <= steps_d;
            wait_q    <= wait_d;
            side_q    <= side_d;
            wall_q    <= wall_d;
            timeout_q <= timeout_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
        end
    end

    assign dda_data_ready_out = ready_q;
    assign valid_hit_out      = (state_q == DONE);
    assign map_addr_out       = addr_q;
    assign map_rd_out         = rd_q;
    assign hcount_out         = hcount_q;
    assign side_out           = side_q;
    assign dist_out           = side_q ? prev_y : prev_x;
    assign wall_type_out      = wall_q;
    assign timeout_out        = timeout_q;
`ifdef DDA_STEP_COUNT_EN
    assign step_count_out     = steps_q;
`endif

endmodule

// File: tb/tb_dda_ray_stepper.sv
// Randomized self-checking bench for dda_ray_stepper against a plain-arithmetic
// DDA walk model and a latency-accurate map BRAM model.
module tb_dda_ray_stepper;
    import raycast_pkg::*;

    localparam int TB_LAT = 2;
    localparam int TB_MAX = 4;
    localparam int STEP_W = $clog2(TB_MAX + 1);

    typedef struct packed {
        logic [15:0] px, py, sdx, sdy, ddx, ddy;
        logic        stepx, stepy;
        logic [8:0]  hc;
    } ray_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_ray_in = 1'b0;
    logic dda_data_ready_out;
    logic [15:0] posX = '0, posY = '0, sideDistX = '0, sideDistY = '0;
    logic [15:0] deltaDistX = '0, deltaDistY = '0;
    logic stepX = 1'b0, stepY = 1'b0;
    logic [8:0] hcount_in = '0;
    logic [MAP_AW-1:0] map_addr_out;
    logic map_rd_out;
    logic [WALL_W-1:0] map_data_in;
    logic valid_hit_out;
    logic hit_ready_in = 1'b0;
    logic [8:0] hcount_out;
    logic [15:0] dist_out;
    logic side_out;
    logic [WALL_W-1:0] wall_type_out;
    logic timeout_out;
`ifdef DDA_STEP_COUNT_EN
    logic [STEP_W-1:0] step_count_out;
`endif

    int testsRun = 0;
    int failCount = 0;

    logic [WALL_W-1:0] mem [MAP_SIZE*MAP_SIZE];
    logic [WALL_W-1:0] bram_d1, bram_d2;
    int obs_reads[$];
    int exp_reads[$];
    int exp_dist, exp_side, exp_wall, exp_timeout, exp_steps;

    dda_ray_stepper #(.MAP_LATENCY(TB_LAT), .MAX_STEPS(TB_MAX)) dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst),
        .valid_ray_in       (valid_ray_in),
        .dda_data_ready_out (dda_data_ready_out),
        .posX               (posX),
        .posY               (posY),
        .stepX              (stepX),
        .stepY              (stepY),
        .sideDistX          (sideDistX),
        .sideDistY          (sideDistY),
        .deltaDistX         (deltaDistX),
        .deltaDistY         (deltaDistY),
        .hcount_in          (hcount_in),
        .map_addr_out       (map_addr_out),
        .map_rd_out         (map_rd_out),
        .map_data_in        (map_data_in),
        .valid_hit_out      (valid_hit_out),
        .hit_ready_in       (hit_ready_in),
        .hcount_out         (hcount_out),
        .dist_out           (dist_out),
        .side_out           (side_out),
        .wall_type_out      (wall_type_out),
        .timeout_out        (timeout_out)
`ifdef DDA_STEP_COUNT_EN
        ,
        .step_count_out     (step_count_out)
`endif
    );

    always #5 clk = ~clk;

    // Two-stage BRAM: data for a strobed address appears TB_LAT cycles later, junk otherwise
    always @(posedge clk) begin
        bram_d1 <= map_rd_out ? mem[map_addr_out] : WALL_W'($urandom);
        bram_d2 <= bram_d1;
    end
    assign map_data_in = bram_d2;

    always @(negedge clk) begin
        if (map_rd_out === 1'b1) obs_reads.push_back(int'(map_addr_out));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMap();
        for (int i = 0; i < MAP_SIZE*MAP_SIZE; i++) mem[i] = '0;
    endtask

    task automatic randomMap();
        for (int i = 0; i < MAP_SIZE*MAP_SIZE; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? WALL_W'($urandom_range(1, 15)) : '0;
    endtask

    // Reference walk straight from the DDA rules using integer arithmetic
    task automatic modelRay(input ray_t r);
        int mx, my, sx, sy, px, py, n, a;
        mx = int'(r.px) / 256;
        my = int'(r.py) / 256;
        sx = int'(r.sdx);
        sy = int'(r.sdy);
        px = 0; py = 0; n = 0;
        exp_reads.delete();
        exp_timeout = 0;
        exp_wall = 0;
        exp_side = 0;
        while (1) begin
            n++;
            if (sx < sy) begin
                px = sx;
                sx = (sx + int'(r.ddx) > 65535) ? 65535 : sx + int'(r.ddx);
                exp_side = 0;
                if ((r.stepx && mx == MAP_SIZE-1) || (!r.stepx && mx == 0)) begin
                    exp_wall = int'(OOB_TYPE);
                    break;
                end
                mx = r.stepx ? mx + 1 : mx - 1;
            end else begin
                py = sy;
                sy = (sy + int'(r.ddy) > 65535) ? 65535 : sy + int'(r.ddy);
                exp_side = 1;
                if ((r.stepy && my == MAP_SIZE-1) || (!r.stepy && my == 0)) begin
                    exp_wall = int'(OOB_TYPE);
                    break;
                end
                my = r.stepy ? my + 1 : my - 1;
            end
            a = my * MAP_SIZE + mx;
            exp_reads.push_back(a);
            if (mem[a] != 0) begin
                exp_wall = int'(mem[a]);
                break;
            end
            if (n == TB_MAX) begin
                exp_timeout = 1;
                break;
            end
        end
        exp_steps = n;
        exp_dist = exp_side ? py : px;
    endtask

    task automatic applyStimulus(input ray_t r);
        int cnt;
        obs_reads.delete();
        posX = r.px; posY = r.py;
        sideDistX = r.sdx; sideDistY = r.sdy;
        deltaDistX = r.ddx; deltaDistY = r.ddy;
        stepX = r.stepx; stepY = r.stepy;
        hcount_in = r.hc;
        valid_ray_in = 1'b1;
        cnt = 0;
        while (dda_data_ready_out !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt == 50) checkOutput("ray_accept", 32'(dda_data_ready_out), 32'd1);
        @(negedge clk);
        valid_ray_in = 1'b0;
        posX = 16'($urandom); posY = 16'($urandom);
        sideDistX = 16'($urandom); sideDistY = 16'($urandom);
        deltaDistX = 16'($urandom); deltaDistY = 16'($urandom);
        stepX = 1'($urandom); stepY = 1'($urandom);
        hcount_in = 9'($urandom);
    endtask

    task automatic runRay(input ray_t r, input int holdCycles, input bit earlyReady);
        int cnt;
        modelRay(r);
        hit_ready_in = earlyReady;
        applyStimulus(r);
        cnt = 0;
        while (valid_hit_out !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (valid_hit_out !== 1'b1) begin
            checkOutput("hit_valid", 32'(valid_hit_out), 32'd1);
            hit_ready_in = 1'b1;
            @(negedge clk);
            hit_ready_in = 1'b0;
            return;
        end
        checkOutput("dist", 32'(dist_out), 32'(exp_dist));
        checkOutput("side", 32'(side_out), 32'(exp_side));
        checkOutput("wall", 32'(wall_type_out), 32'(exp_wall));
        checkOutput("timeout", 32'(timeout_out), 32'(exp_timeout));
        checkOutput("hcount", 32'(hcount_out), 32'(r.hc));
`ifdef DDA_STEP_COUNT_EN
        checkOutput("steps", 32'(step_count_out), 32'(exp_steps));
`endif
        checkOutput("read_count", 32'(obs_reads.size()), 32'(exp_reads.size()));
        for (int i = 0; i < exp_reads.size() && i < obs_reads.size(); i++)
            checkOutput("read_addr", 32'(obs_reads[i]), 32'(exp_reads[i]));
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(valid_hit_out), 32'd1);
            checkOutput("hold_ready", 32'(dda_data_ready_out), 32'd0);
            checkOutput("hold_dist", 32'(dist_out), 32'(exp_dist));
            checkOutput("hold_wall", 32'(wall_type_out), 32'(exp_wall));
        end
        hit_ready_in = 1'b1;
        @(negedge clk);
        hit_ready_in = 1'b0;
        checkOutput("release_valid", 32'(valid_hit_out), 32'd0);
        checkOutput("release_ready", 32'(dda_data_ready_out), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(valid_hit_out), 32'd0);
        checkOutput({tag, "_ready"}, 32'(dda_data_ready_out), 32'd0);
        checkOutput({tag, "_rd"}, 32'(map_rd_out), 32'd0);
        checkOutput({tag, "_addr"}, 32'(map_addr_out), 32'd0);
        checkOutput({tag, "_dist"}, 32'(dist_out), 32'd0);
        checkOutput({tag, "_hcount"}, 32'(hcount_out), 32'd0);
        checkOutput({tag, "_wall"}, 32'(wall_type_out), 32'd0);
        checkOutput({tag, "_side"}, 32'(side_out), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout_out), 32'd0);
    endtask

    function automatic ray_t mkRay(input logic [15:0] px, py, sdx, sdy, ddx, ddy,
                                   input logic sx, sy, input logic [8:0] hc);
        ray_t r;
        r.px = px; r.py = py; r.sdx = sdx; r.sdy = sdy;
        r.ddx = ddx; r.ddy = ddy; r.stepx = sx; r.stepy = sy; r.hc = hc;
        return r;
    endfunction

    initial begin
        ray_t r;
        int cnt, hold;
        bit early;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(dda_data_ready_out), 32'd1);

        $display("[TB] empty-row hit with backpressure");
        clearMap();
        mem[3*MAP_SIZE + 5] = 4'd3;
        r = mkRay(16'h0380, 16'h0380, 16'h0080, 16'h0200, 16'h0100, 16'h0400, 1'b1, 1'b1, 9'd17);
        runRay(r, 10, 1'b0);

        $display("[TB] tie goes to Y");
        clearMap();
        mem[2*MAP_SIZE + 3] = 4'd5;
        r = mkRay(16'h0380, 16'h0380, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b0, 9'd319);
        runRay(r, 0, 1'b0);

        $display("[TB] out of bounds at low and high edges");
        r = mkRay(16'h0080, 16'h0580, 16'h0080, 16'hFFFF, 16'h0100, 16'h0100, 1'b0, 1'b1, 9'd0);
        runRay(r, 1, 1'b0);
        r = mkRay(16'h1780, 16'h0580, 16'h0010, 16'h0500, 16'h0100, 16'h0100, 1'b1, 1'b1, 9'd200);
        runRay(r, 0, 1'b1);

        $display("[TB] timeout in empty interior");
        clearMap();
        r = mkRay(16'h0C80, 16'h0C80, 16'h0040, 16'h0090, 16'h0100, 16'h0180, 1'b1, 1'b0, 9'd99);
        runRay(r, 2, 1'b0);

        $display("[TB] saturation keeps exact previous distance");
        r = mkRay(16'h0C80, 16'h0C80, 16'hF000, 16'hFFFF, 16'hF000, 16'h0001, 1'b0, 1'b1, 9'd5);
        runRay(r, 0, 1'b0);

        $display("[TB] reset during WAIT");
        clearMap();
        r = mkRay(16'h0C80, 16'h0C80, 16'h0080, 16'h0200, 16'h0100, 16'h0100, 1'b1, 1'b1, 9'd77);
        applyStimulus(r);
        cnt = 0;
        while (map_rd_out !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ready_after", 32'(dda_data_ready_out), 32'd1);
        mem[12*MAP_SIZE + 14] = 4'd9;
        runRay(r, 0, 1'b0);

        $display("[TB] randomized rays");
        for (int t = 0; t < 40; t++) begin
            randomMap();
            r.px = 16'($urandom_range(0, MAP_SIZE*256 - 1));
            r.py = 16'($urandom_range(0, MAP_SIZE*256 - 1));
            r.stepx = 1'($urandom);
            r.stepy = 1'($urandom);
            r.hc = 9'($urandom_range(0, SCREEN_W - 1));
            if ($urandom_range(0, 4) == 0) begin
                r.sdx = 16'($urandom_range(16'hE000, 16'hFFFF));
                r.sdy = 16'($urandom_range(16'hE000, 16'hFFFF));
                r.ddx = 16'($urandom_range(16'h4000, 16'hFFFF));
                r.ddy = 16'($urandom_range(16'h4000, 16'hFFFF));
            end else begin
                r.sdx = 16'($urandom_range(0, 16'h0300));
                r.sdy = 16'($urandom_range(0, 16'h0300));
                r.ddx = 16'($urandom_range(0, 16'h0800));
                r.ddy = 16'($urandom_range(0, 16'h0800));
            end
            hold = $urandom_range(0, 3);
            early = (hold == 0) && ($urandom_range(0, 1) == 1);
            runRay(r, hold, early);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
